bus_arbiter: RTL and testbench

Shares one single-port instruction/data memory bus between the instruction-fetch (IF) port and the MEM-stage data port of the five-stage core. It runs a three-state grant FSM with registered bus outputs, a per-transaction timeout watchdog, and a stall request to the pipeline control. Data accesses take priority, with a starvation guard for fetch. It sits between `pc_reg`/`mem` and the external memory, replacing the direct ROM connection.

---
 rtl/bus_arbiter_pkg.sv | 18 +
 rtl/bus_watchdog.sv | 35 +++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the IF/MEM memory bus arbiter: FSM encoding, grant
// history flag and the fetch byte-enable constant.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_DATA = 2'b01,
      ARB_INST = 2'b10
   } arb_state_t;

   typedef enum logic {
      GRANT_INST = 1'b0,
      GRANT_DATA = 1'b1
   } grant_t;

   localparam logic [3:0] BUS_SEL_ALL = 4'b1111;

endpackage

// File: rtl/bus_watchdog.sv
// Per-transaction wait counter: cleared on grant, counts un-acked owned
// cycles, saturates at TIMEOUT and flags expiry. TIMEOUT=0 removes it.
module bus_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expire = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT + 1);
         localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

         logic [CW-1:0] cnt_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               cnt_q <= '0;
            else if (clr)
               cnt_q <= '0;
            else if (en && cnt_q != LIMIT)
               cnt_q <= cnt_q + CW'(1);
         end

         assign expire = (cnt_q == LIMIT);
      end
   endgenerate

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and the MEM
// stage data port; data has priority, alternating after a data completion.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [3:0]        dm_sel,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              stallreq_o
);

   arb_state_t state_q, state_d;
   grant_t     last_grant_q;
   logic       dm_live, if_live;
   logic       grant_dm, grant_if;
   logic       owned, done, expire;

   // A request whose ack is on the wire this cycle is already served.
   assign dm_live    = dm_req & ~dm_ack;
   assign if_live    = if_req & ~if_ack;
   assign stallreq_o = dm_live | if_live;

   assign owned = (state_q != ARB_IDLE);
   assign done  = owned & (bus_ack | expire);

   always_comb begin
      grant_dm = 1'b0;
      grant_if = 1'b0;
      state_d  = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (dm_live && (!if_live || last_grant_q == GRANT_INST)) begin
               grant_dm = 1'b1;
               state_d  = ARB_DATA;
            end else if (if_live) begin
               grant_if = 1'b1;
               state_d  = ARB_INST;
            end
         end
         ARB_DATA, ARB_INST: begin
            if (bus_ack || expire)
               state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (grant_dm | grant_if),
      .en     (owned & ~bus_ack),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= GRANT_INST;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_sel      <= '0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         if_rdata     <= '0;
         if_ack       <= 1'b0;
         dm_rdata     <= '0;
         dm_ack       <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         state_q <= state_d;
         if_ack  <= 1'b0;
         dm_ack  <= 1'b0;
         bus_err <= 1'b0;

         if (grant_dm) begin
            bus_req   <= 1'b1;
            bus_we    <= dm_we;
            bus_sel   <= dm_sel;
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
         end else if (grant_if) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_sel  <= BUS_SEL_ALL;
            bus_addr <= if_addr;
         end

         // A real ack wins over a same-cycle expiry.
         if (done) begin
            bus_req <= 1'b0;
            bus_err <= ~bus_ack;
            if (state_q == ARB_DATA) begin
               last_grant_q <= GRANT_DATA;
               dm_ack       <= 1'b1;
               dm_rdata     <= bus_ack ? bus_rdata : '0;
            end else begin
               last_grant_q <= GRANT_INST;
               if_ack       <= 1'b1;
               if_rdata     <= bus_ack ? bus_rdata : '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: requesters push expected acks into
// per-port queues; a negedge monitor pops and compares each ack.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [3:0]  dm_sel = '0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        bus_err;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        stallreq_o;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] rdata;
      bit          chk_data;
      bit          err;
      int          at;
   } exp_t;

   exp_t if_q[$];
   exp_t dm_q[$];

   // Memory model: acks after mem_wait un-acked cycles; -1 never acks.
   int mem_wait = 0;
   int mem_cnt  = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0004: return 32'h3401_1100;
         32'h0000_0008: return 32'h0000_0013;
         32'h0000_0100: return 32'hDEAD_BEEF;
         32'h0000_0300: return 32'hCAFE_F00D;
         default:       return 32'h0BAD_0BAD;
      endcase
   endfunction

   assign bus_rdata = bus_req ? mem_word(bus_addr) : 32'h0;
   assign bus_ack   = bus_req && (mem_wait >= 0) && (mem_cnt == mem_wait);

   always @(posedge clk) begin
      if (!bus_req || bus_ack) mem_cnt <= 0;
      else                     mem_cnt <= mem_cnt + 1;
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_ack     (if_ack),
      .dm_req     (dm_req),
      .dm_we      (dm_we),
      .dm_sel     (dm_sel),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_rdata   (dm_rdata),
      .dm_ack     (dm_ack),
      .bus_err    (bus_err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_sel    (bus_sel),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_ack    (bus_ack),
      .stallreq_o (stallreq_o)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic cmp_ack(input string name, input exp_t e, input logic [31:0] rd);
      vectors++;
      if (cyc != e.at || bus_err !== e.err || (e.chk_data && rd !== e.rdata)) begin
         miscompares++;
         $display("FAIL %s: got cycle %0d rdata %h err %b, want cycle %0d rdata %h err %b",
                  name, cyc, rd, bus_err, e.at, e.rdata, e.err);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (if_ack) begin
            if (if_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL if_ack unexpected at cycle %0d", cyc);
            end else cmp_ack("if_ack", if_q.pop_front(), if_rdata);
         end
         if (dm_ack) begin
            if (dm_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL dm_ack unexpected at cycle %0d", cyc);
            end else cmp_ack("dm_ack", dm_q.pop_front(), dm_rdata);
         end
         if (bus_err && !if_ack && !dm_ack) begin
            vectors++; miscompares++;
            $display("FAIL bus_err without ack at cycle %0d", cyc);
         end
      end
   end

   // Raise a request at the next edge; lat is the expected ack cycle offset.
   task automatic req(input bit dm, input bit we, input logic [3:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input bit chk_d, input bit exp_err,
                      input int lat, input bit hold);
      exp_t e;
      int n;
      @(posedge clk); #1;
      e.rdata = exp_rd; e.chk_data = chk_d; e.err = exp_err; e.at = cyc + lat;
      if (dm) begin
         dm_q.push_back(e);
         dm_req = 1'b1; dm_we = we; dm_sel = sel; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_q.push_back(e);
         if_req = 1'b1; if_addr = addr;
      end
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(dm ? dm_ack : if_ack) && n < 40);
      if (!(dm ? dm_ack : if_ack)) begin
         vectors++; miscompares++;
         $display("FAIL %s ack: none within 40 cycles of request", dm ? "dm" : "if");
      end
      if (!hold) begin
         @(posedge clk); #1;
         if (dm) dm_req = 1'b0; else if_req = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global time limit reached");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset bus_req", {31'b0, bus_req}, 32'h0);
      chk("reset acks/err", {29'b0, if_ack, dm_ack, bus_err}, 32'h0);
      chk("reset bus_addr", bus_addr, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("post-reset stall", {31'b0, stallreq_o}, 32'h0);

      // Single zero-wait fetch
      mem_wait = 0;
      fork
         req(0, 0, 4'h0, 32'h4, 32'h0, 32'h3401_1100, 1, 0, 2, 0);
         begin
            @(posedge clk);
            @(negedge clk); chk("fetch bus_req c0", {31'b0, bus_req}, 32'h0);
            @(negedge clk); chk("fetch bus_req c1", {31'b0, bus_req}, 32'h1);
            chk("fetch bus_addr c1", bus_addr, 32'h4);
            chk("fetch bus_sel/we c1", {27'b0, bus_sel, bus_we}, {27'b0, 4'hF, 1'b0});
            @(negedge clk); chk("fetch bus_req c2", {31'b0, bus_req}, 32'h0);
         end
      join

      // Collision with last grant INST: data first, fetch granted in ack cycle
      fork
         req(1, 0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 0, 2, 0);
         req(0, 0, 4'h0, 32'h8, 32'h0, 32'h0000_0013, 1, 0, 4, 0);
      join

      // Back-to-back stores with fetch pending: fetch slips in between
      fork
         begin
            req(1, 1, 4'hF, 32'h204, 32'h1, 32'h0, 0, 0, 2, 1);
            req(1, 1, 4'hF, 32'h208, 32'h2, 32'h0, 0, 0, 3, 0);
         end
         req(0, 0, 4'h0, 32'hC, 32'h0, 32'h0BAD_0BAD, 1, 0, 4, 0);
      join

      // Last grant DATA and both raised together: fetch wins
      fork
         req(1, 0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 0, 4, 0);
         req(0, 0, 4'h0, 32'h4, 32'h0, 32'h3401_1100, 1, 0, 2, 0);
      join

      // Store with 3 wait states: stable bus and stall until dm_ack
      mem_wait = 3;
      fork
         req(1, 1, 4'b0011, 32'h200, 32'h1234_5678, 32'h0, 0, 0, 5, 0);
         begin
            @(posedge clk);
            for (int c = 0; c <= 5; c++) begin
               @(negedge clk);
               chk($sformatf("wait stall c%0d", c), {31'b0, stallreq_o}, (c < 5) ? 32'h1 : 32'h0);
               if (c >= 1 && c <= 4) begin
                  chk($sformatf("wait bus_req c%0d", c), {31'b0, bus_req}, 32'h1);
                  chk($sformatf("wait we/sel c%0d", c), {27'b0, bus_we, bus_sel}, {27'b0, 1'b1, 4'b0011});
                  chk($sformatf("wait addr c%0d", c), bus_addr, 32'h200);
                  chk($sformatf("wait wdata c%0d", c), bus_wdata, 32'h1234_5678);
               end
            end
         end
      join

      // Watchdog timeout on a fetch (TIMEOUT=4 -> ack at cycle 6)
      mem_wait = -1;
      fork
         req(0, 0, 4'h0, 32'h40, 32'h0, 32'h0, 1, 1, 6, 0);
         begin
            @(posedge clk);
            for (int c = 0; c <= 7; c++) begin
               @(negedge clk);
               if (c == 5) chk("timeout bus_req c5", {31'b0, bus_req}, 32'h1);
               if (c >= 6) chk($sformatf("timeout bus_req c%0d", c), {31'b0, bus_req}, 32'h0);
            end
         end
      join
      mem_wait = 0;
      req(0, 0, 4'h0, 32'h4, 32'h0, 32'h3401_1100, 1, 0, 2, 0);

      // Reset while DATA owns the bus
      mem_wait = 5;
      @(posedge clk); #1;
      dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h300;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid bus_req before reset", {31'b0, bus_req}, 32'h1);
      #2;
      rst = 1'b0; dm_req = 1'b0;
      #1;
      chk("async reset bus_req", {31'b0, bus_req}, 32'h0);
      chk("async reset bus_addr", bus_addr, 32'h0);
      chk("async reset sel/we/acks", {24'b0, bus_sel, bus_we, if_ack, dm_ack, bus_err}, 32'h0);
      chk("async reset stall", {31'b0, stallreq_o}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      mem_wait = 0;
      req(1, 0, 4'hF, 32'h300, 32'h0, 32'hCAFE_F00D, 1, 0, 2, 0);

      repeat (3) @(negedge clk);
      chk("if queue drained", if_q.size(), 32'h0);
      chk("dm queue drained", dm_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
